// File: rtl/workout_pkg.sv
// rtl/workout_pkg.sv - phase codes shared by the workout controller and the LCD controller
package workout_pkg;

  localparam logic [2:0] PHASE_IDLE   = 3'd0;
  localparam logic [2:0] PHASE_WORK   = 3'd1;
  localparam logic [2:0] PHASE_REST   = 3'd2;
  localparam logic [2:0] PHASE_PAUSED = 3'd3;
  localparam logic [2:0] PHASE_DONE   = 3'd4;

  typedef enum logic [2:0] {
    PH_IDLE   = PHASE_IDLE,
    PH_WORK   = PHASE_WORK,
    PH_REST   = PHASE_REST,
    PH_PAUSED = PHASE_PAUSED,
    PH_DONE   = PHASE_DONE
  } phase_t;

endpackage

// File: rtl/workout_session_ctrl_tick_divider.sv
// rtl/workout_session_ctrl_tick_divider.sv - clock-enable divider, wrap strobe every DIV enabled cycles
module tick_divider #(
  parameter int DIV = 50_000_000
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic wrap
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  // Combinational strobe so the owner registers its reaction on the wrap edge.
  assign wrap = en && (cnt == CW'(DIV - 1));

  always_ff @(posedge clk_sys) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en) begin
      if (wrap) cnt <= '0;
      else      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/workout_session_ctrl.sv
// rtl/workout_session_ctrl.sv - exercise/rest sequencer with pause, beep gating and session done
module workout_session_ctrl
  import workout_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TONE_HZ = 2000,
  parameter int N_EX    = 8,
  parameter int T_W     = 8,
  parameter int REST_S  = 10,
  parameter int BEEP_S  = 2,
  localparam int IDX_W  = $clog2(N_EX)
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             start,
  input  logic             skip,
  input  logic             pause,
  input  logic [T_W-1:0]   T_in,
  output logic [IDX_W-1:0] workout_num,
  output logic [T_W-1:0]   time_remain,
  output logic [2:0]       phase,
  output logic             tick_1hz,
  output logic             buzzer,
  output logic             done
);

  localparam int BW = $clog2(BEEP_S + 1);

  phase_t           state, state_n, ret_phase, ret_n;
  logic [IDX_W-1:0] num_n;
  logic [T_W-1:0]   tr_n, t_load;
  logic [BW-1:0]    beep_cnt, beep_n;
  logic             tick_n, end_int;
  logic             sec_wrap, tone_wrap, tone;

  // Seconds divider holds its count while paused so resume loses no fraction.
  tick_divider #(.DIV(CLK_HZ)) u_sec_div (
    .clk_sys (clk_sys),
    .reset   (reset),
    .clr     (start),
    .en      (state != PH_PAUSED),
    .wrap    (sec_wrap)
  );

  tick_divider #(.DIV(CLK_HZ / (2 * TONE_HZ))) u_tone_div (
    .clk_sys (clk_sys),
    .reset   (reset),
    .clr     (1'b0),
    .en      (1'b1),
    .wrap    (tone_wrap)
  );

  assign t_load = (T_in == '0) ? T_W'(1) : T_in;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state       <= PH_IDLE;
      ret_phase   <= PH_IDLE;
      workout_num <= '0;
      time_remain <= '0;
      beep_cnt    <= '0;
      tick_1hz    <= 1'b0;
      tone        <= 1'b0;
      buzzer      <= 1'b0;
    end else begin
      state       <= state_n;
      ret_phase   <= ret_n;
      workout_num <= num_n;
      time_remain <= tr_n;
      beep_cnt    <= beep_n;
      tick_1hz    <= tick_n;
      if (tone_wrap) tone <= ~tone;
      buzzer      <= tone && (beep_cnt != '0);
    end
  end

  always_comb begin
    state_n = state;
    ret_n   = ret_phase;
    num_n   = workout_num;
    tr_n    = time_remain;
    beep_n  = beep_cnt;
    tick_n  = 1'b0;
    end_int = 1'b0;

    if (sec_wrap && (state != PH_PAUSED) && (beep_cnt != '0))
      beep_n = beep_cnt - 1'b1;

    if (start) begin
      state_n = PH_WORK;
      num_n   = '0;
      tr_n    = t_load;
      beep_n  = '0;
    end else begin
      case (state)
        PH_WORK, PH_REST: begin
          if (skip) begin
            end_int = 1'b1;
          end else if (pause) begin
            state_n = PH_PAUSED;
            ret_n   = state;
          end else if (sec_wrap) begin
            tick_n = 1'b1;
            if (time_remain > T_W'(1)) tr_n = time_remain - 1'b1;
            else                       end_int = 1'b1;
          end
        end
        PH_PAUSED: if (pause) state_n = ret_phase;
        default: ;
      endcase
    end

    // Interval end is shared by tick expiry and skip.
    if (end_int) begin
      if (state == PH_WORK) begin
        beep_n = BW'(BEEP_S);
        if (workout_num == IDX_W'(N_EX - 1)) begin
          state_n = PH_DONE;
          tr_n    = '0;
        end else if (REST_S == 0) begin
          state_n = PH_WORK;
          num_n   = workout_num + 1'b1;
          tr_n    = t_load;
        end else begin
          state_n = PH_REST;
          tr_n    = T_W'(REST_S);
        end
      end else begin
        state_n = PH_WORK;
        num_n   = workout_num + 1'b1;
        tr_n    = t_load;
      end
    end
  end

  always_comb begin
    phase = state;
    done  = (state == PH_DONE);
  end

endmodule

// File: tb/tb_workout_session_ctrl.sv
// tb/tb_workout_session_ctrl.sv - directed scoreboard bench for workout_session_ctrl
module tb_workout_session_ctrl;

  logic       clk_sys = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       skip = 1'b0;
  logic       pause = 1'b0;
  logic [7:0] T_in = 8'd3;
  logic [1:0] workout_num;
  logic [7:0] time_remain;
  logic [2:0] phase;
  logic       tick_1hz;
  logic       buzzer;
  logic       done;

  workout_session_ctrl #(
    .CLK_HZ(20), .TONE_HZ(5), .N_EX(3), .T_W(8), .REST_S(2), .BEEP_S(1)
  ) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .start       (start),
    .skip        (skip),
    .pause       (pause),
    .T_in        (T_in),
    .workout_num (workout_num),
    .time_remain (time_remain),
    .phase       (phase),
    .tick_1hz    (tick_1hz),
    .buzzer      (buzzer),
    .done        (done)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    string       tag;
    logic [14:0] v;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   hi;

  task automatic step();
    @(negedge clk_sys);
    cyc++;
  endtask

  task automatic goto(int t);
    while (cyc < t) step();
  endtask

  // m bit0=start, bit1=skip, bit2=pause; cycle count restarts at a start edge
  task automatic pulse(int m);
    start = m[0];
    skip  = m[1];
    pause = m[2];
    step();
    start = 1'b0;
    skip  = 1'b0;
    pause = 1'b0;
    if (m[0]) cyc = 0;
  endtask

  task automatic check_sb();
    exp_t        e;
    logic [14:0] obs;
    e   = sb.pop_front();
    obs = {phase, workout_num, time_remain, tick_1hz, done};
    checks++;
    assert (obs === e.v) else begin
      errors++;
      $error("FAIL %s: observed phase=%0d num=%0d remain=%0d tick=%b done=%b, expected phase=%0d num=%0d remain=%0d tick=%b done=%b",
             e.tag, obs[14:12], obs[11:10], obs[9:2], obs[1], obs[0],
             e.v[14:12], e.v[11:10], e.v[9:2], e.v[1], e.v[0]);
    end
  endtask

  task automatic at(int t, string tag, logic [2:0] ph, logic [1:0] n, logic [7:0] tr, logic tk);
    exp_t e;
    e.tag = tag;
    e.v   = {ph, n, tr, tk, (ph == 3'd4)};
    sb.push_back(e);
    goto(t);
    check_sb();
  endtask

  task automatic check_val(string tag, int obs, int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic count_buzz(int t_end, output int n_hi);
    n_hi = 0;
    while (cyc < t_end) begin
      step();
      if (buzzer === 1'b1) n_hi++;
    end
  endtask

  initial begin
    step();
    step();
    reset = 1'b0;
    at(cyc, "reset_state", 3'd0, 2'd0, 8'd0, 1'b0);
    check_val("reset_buzzer", int'(buzzer), 0);

    // Full session, T_in=3
    T_in = 8'd3;
    pulse(1);
    at(0,   "work0_entry",   3'd1, 2'd0, 8'd3, 1'b0);
    at(19,  "work0_pre_tick", 3'd1, 2'd0, 8'd3, 1'b0);
    at(20,  "work0_tick1",   3'd1, 2'd0, 8'd2, 1'b1);
    at(40,  "work0_tick2",   3'd1, 2'd0, 8'd1, 1'b1);
    at(60,  "rest0_entry",   3'd2, 2'd0, 8'd2, 1'b1);
    count_buzz(80, hi);
    check_val("beep0_high_cycles", hi, 10);
    at(80,  "rest0_tick",    3'd2, 2'd0, 8'd1, 1'b1);
    step();
    check_val("beep0_silent", int'(buzzer), 0);
    at(100, "work1_entry",   3'd1, 2'd1, 8'd3, 1'b1);
    at(160, "rest1_entry",   3'd2, 2'd1, 8'd2, 1'b1);
    at(200, "work2_entry",   3'd1, 2'd2, 8'd3, 1'b1);
    at(259, "work2_last",    3'd1, 2'd2, 8'd1, 1'b0);
    at(260, "done_entry",    3'd4, 2'd2, 8'd0, 1'b1);
    count_buzz(280, hi);
    check_val("final_beep_high_cycles", hi, 10);
    at(300, "done_hold",     3'd4, 2'd2, 8'd0, 1'b0);
    check_val("final_beep_silent", int'(buzzer), 0);

    // Skip in WORK and in REST
    pulse(1);
    at(20,  "skip_pre",      3'd1, 2'd0, 8'd2, 1'b1);
    pulse(2);
    at(21,  "skip_to_rest",  3'd2, 2'd0, 8'd2, 1'b0);
    count_buzz(25, hi);
    check_val("skip_beep_high", hi, 2);
    pulse(2);
    at(26,  "skip_to_work1", 3'd1, 2'd1, 8'd3, 1'b0);

    // Pause 10 cycles into a second, held 100 cycles
    pulse(1);
    at(20,  "pause_pre",     3'd1, 2'd0, 8'd2, 1'b1);
    goto(29);
    pulse(4);
    at(30,  "paused",        3'd3, 2'd0, 8'd2, 1'b0);
    at(80,  "paused_mid",    3'd3, 2'd0, 8'd2, 1'b0);
    pulse(2);
    at(81,  "paused_skip",   3'd3, 2'd0, 8'd2, 1'b0);
    goto(130);
    pulse(4);
    at(131, "resumed",       3'd1, 2'd0, 8'd2, 1'b0);
    at(140, "resume_pre_tick", 3'd1, 2'd0, 8'd2, 1'b0);
    at(141, "resume_tick",   3'd1, 2'd0, 8'd1, 1'b1);

    // T_in=0 treated as one second; start beats skip
    T_in = 8'd0;
    pulse(1);
    at(0,   "tin0_entry",    3'd1, 2'd0, 8'd1, 1'b0);
    at(19,  "tin0_hold",     3'd1, 2'd0, 8'd1, 1'b0);
    at(20,  "tin0_end",      3'd2, 2'd0, 8'd2, 1'b1);
    at(60,  "tin0_work1",    3'd1, 2'd1, 8'd1, 1'b1);
    T_in = 8'd3;
    goto(65);
    pulse(3);
    at(0,   "start_beats_skip", 3'd1, 2'd0, 8'd3, 1'b0);

    // Reset during an active beep in REST
    goto(5);
    pulse(2);
    at(6,   "rest_before_reset", 3'd2, 2'd0, 8'd2, 1'b0);
    count_buzz(10, hi);
    check_val("rest_beep_active", hi, 2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    at(cyc, "after_reset",   3'd0, 2'd0, 8'd0, 1'b0);
    check_val("after_reset_buzzer", int'(buzzer), 0);
    count_buzz(cyc + 10, hi);
    check_val("idle_silent", hi, 0);
    pulse(4);
    at(cyc, "idle_pause",    3'd0, 2'd0, 8'd0, 1'b0);
    pulse(2);
    at(cyc, "idle_skip",     3'd0, 2'd0, 8'd0, 1'b0);
    at(cyc + 30, "idle_hold", 3'd0, 2'd0, 8'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
